// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its next-PC selector.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;
  localparam logic [5:0]  OPC_J     = 6'b000010;
  localparam logic [5:0]  OPC_BEQ   = 6'b000100;

  // Primary opcode field of a MIPS-style instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: sequential PC+4, BEQ target or J target,
// plus the redirect qualifier for the instruction currently held in IF/ID.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] if_id_pc4,
  input  logic [25:0]       jump_index,
  input  logic [31:0]       branch_offset,
  input  logic              if_id_valid,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] target,
  output logic              redirect
);

  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;

  assign pc_plus4      = pc + ADDR_W'(PC_INC);
  // Offset counts words; the add wraps naturally at the address width.
  assign branch_target = if_id_pc4 + ADDR_W'(branch_offset << 2);
  assign jump_target   = ADDR_W'({if_id_pc4[ADDR_W-1 -: 4], jump_index, 2'b00});

  assign redirect = if_id_valid & ((branch & zero) | jump);
  assign target   = jump ? jump_target : branch_target;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage with IF/ID register: req/ack instruction fetch, stall skid buffer,
// branch/jump redirect with in-flight discard. Optional counters via FETCH_PERF_CNT_EN.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       BranchOffset,
  input  logic              Jump,
  output logic [DATA_W-1:0] IF_ID_Instr,
  output logic [ADDR_W-1:0] IF_ID_PC4,
  output logic              IF_ID_Valid,
  output logic [5:0]        OpCode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_e      state_reg, state_next;
  logic              started_reg;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] drop_addr_reg, drop_addr_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic [DATA_W-1:0] if_id_instr_reg, if_id_instr_next;
  logic [ADDR_W-1:0] if_id_pc4_reg, if_id_pc4_next;
  logic              if_id_valid_reg, if_id_valid_next;
  logic              load_fire;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              ack_eff;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc            (pc_reg),
    .if_id_pc4     (if_id_pc4_reg),
    .jump_index    (if_id_instr_reg[25:0]),
    .branch_offset (BranchOffset),
    .if_id_valid   (if_id_valid_reg),
    .branch        (Branch),
    .zero          (Zero),
    .jump          (Jump),
    .pc_plus4      (pc_plus4),
    .target        (target),
    .redirect      (redirect)
  );

  // started_reg keeps the request low while reset is asserted and releases it one edge later.
  assign imem_req  = started_reg & (state_reg != HOLD);
  assign imem_addr = (state_reg == DISCARD) ? drop_addr_reg : pc_reg;
  assign ack_eff   = imem_ack & imem_req;

  assign IF_ID_Instr = if_id_instr_reg;
  assign IF_ID_PC4   = if_id_pc4_reg;
  assign IF_ID_Valid = if_id_valid_reg;
  assign OpCode      = opcode_of(32'(if_id_instr_reg));

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    drop_addr_next   = drop_addr_reg;
    skid_next        = skid_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_pc4_next   = if_id_pc4_reg;
    if_id_valid_next = if_id_valid_reg;
    load_fire        = 1'b0;

    if (redirect) begin
      if_id_valid_next = 1'b0;
      if_id_instr_next = DATA_W'(NOP_INSTR);
      skid_next        = DATA_W'(NOP_INSTR);
      pc_next          = target;
      // An unacked request must still complete on the bus at its original address.
      if (imem_req && !ack_eff) begin
        state_next = DISCARD;
        if (state_reg != DISCARD) begin
          drop_addr_next = imem_addr;
        end
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (ack_eff) begin
            if (stall) begin
              skid_next  = imem_rdata;
              state_next = HOLD;
            end else begin
              if_id_instr_next = imem_rdata;
              if_id_pc4_next   = pc_plus4;
              if_id_valid_next = 1'b1;
              pc_next          = pc_plus4;
              load_fire        = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_instr_next = skid_reg;
            if_id_pc4_next   = pc_plus4;
            if_id_valid_next = 1'b1;
            pc_next          = pc_plus4;
            load_fire        = 1'b1;
            state_next       = RUN;
          end
        end
        DISCARD: begin
          if (ack_eff) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      started_reg     <= 1'b0;
      pc_reg          <= ADDR_W'(RESET_PC);
      drop_addr_reg   <= '0;
      skid_reg        <= DATA_W'(NOP_INSTR);
      if_id_instr_reg <= DATA_W'(NOP_INSTR);
      if_id_pc4_reg   <= '0;
      if_id_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      started_reg     <= 1'b1;
      pc_reg          <= pc_next;
      drop_addr_reg   <= drop_addr_next;
      skid_reg        <= skid_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_pc4_reg   <= if_id_pc4_next;
      if_id_valid_reg <= if_id_valid_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (load_fire) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (stall)     stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  logic unused_load_fire;
  assign unused_load_fire = load_fire;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus randomized
// traffic checked against a transaction-level fetch model.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] BranchOffset = '0;
  logic        Jump = 1'b0;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [5:0]  OpCode;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .Branch(Branch), .Zero(Zero),
    .BranchOffset(BranchOffset), .Jump(Jump),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid), .OpCode(OpCode)
  );

  always #5 clk = ~clk;

  // Reference model: architectural next-fetch PC, IF/ID contents, a word parked
  // by a stall, and an abandoned request whose data must be thrown away.
  logic        m_started, m_valid, m_parked, m_drop;
  logic [31:0] m_pc, m_instr, m_pc4, m_parked_word, m_drop_addr;

  function automatic logic exp_req();
    return m_started && !m_parked;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  task automatic model_reset();
    m_started = 0; m_valid = 0; m_parked = 0; m_drop = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_parked_word = 0; m_drop_addr = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
  task automatic cycle(input logic a, input logic [31:0] rd, input logic st,
                       input logic br, input logic z, input logic [31:0] off, input logic j);
    logic req_now, ack_now, redir;
    logic [31:0] addr_now, tgt;
    imem_ack = a; imem_rdata = rd; stall = st;
    Branch = br; Zero = z; BranchOffset = off; Jump = j;
    req_now  = exp_req();
    addr_now = exp_addr();
    ack_now  = a && req_now;
    redir    = m_valid && ((br && z) || j);
    tgt      = j ? {m_pc4[31:28], m_instr[25:0], 2'b00} : m_pc4 + off * 32'd4;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1;
    end else if (redir) begin
      m_valid = 0; m_instr = 0; m_parked = 0;
      if (req_now && !ack_now) begin
        if (!m_drop) begin m_drop = 1; m_drop_addr = addr_now; end
      end else begin
        m_drop = 0;
      end
      m_pc = tgt;
    end else if (m_drop) begin
      if (ack_now) m_drop = 0;
    end else if (m_parked) begin
      if (!st) begin
        m_instr = m_parked_word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_parked = 0;
      end
    end else if (ack_now) begin
      if (st) begin
        m_parked = 1; m_parked_word = rd;
      end else begin
        m_instr = rd; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", imem_req); end
    n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", IF_ID_Valid); end
    n_vec++; if (IF_ID_Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h want=0", IF_ID_Instr); end
    n_vec++; if (IF_ID_PC4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got=%h want=0", IF_ID_PC4); end
    n_vec++; if (OpCode !== 6'h0) begin n_err++; $display("FAIL reset_opcode got=%b want=0", OpCode); end
    rst_n = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  task automatic test_zero_wait();
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL first_req got=%b/%h want=1/0", imem_req, imem_addr); end
    cycle(1, 32'h2008_0005, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_Instr !== 32'h2008_0005) begin n_err++; $display("FAIL zw_instr got=%h want=20080005", IF_ID_Instr); end
    n_vec++; if (OpCode !== 6'b001000) begin n_err++; $display("FAIL zw_opcode got=%b want=001000", OpCode); end
    n_vec++; if (IF_ID_PC4 !== 32'h4 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL zw_pc4 got=%h/%b want=4/1", IF_ID_PC4, IF_ID_Valid); end
    n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL zw_next_addr got=%h want=4", imem_addr); end
    $display("zero-wait fetch: instr=%h pc4=%h", IF_ID_Instr, IF_ID_PC4);
  endtask

  task automatic test_delayed_ack();
    logic [31:0] jw;
    int req_cycles;
    jw = {OPC_J, 26'h10};
    req_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      if (imem_req === 1'b1) req_cycles++;
      n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL delay_addr[%0d] got=%h want=4", k, imem_addr); end
      cycle(0, $urandom, 0, 0, 0, 0, 0);
      n_vec++; if (IF_ID_Instr !== 32'h2008_0005) begin n_err++; $display("FAIL delay_hold[%0d] got=%h want=20080005", k, IF_ID_Instr); end
    end
    if (imem_req === 1'b1) req_cycles++;
    cycle(1, jw, 0, 0, 0, 0, 0);
    n_vec++; if (req_cycles != 4) begin n_err++; $display("FAIL delay_req_cycles got=%0d want=4", req_cycles); end
    n_vec++; if (IF_ID_Instr !== jw || IF_ID_PC4 !== 32'h8) begin n_err++; $display("FAIL delay_load got=%h/%h want=%h/8", IF_ID_Instr, IF_ID_PC4, jw); end
    $display("delayed ack: req cycles=%0d instr=%h", req_cycles, IF_ID_Instr);
  endtask

  task automatic test_jump();
    cycle(1, 32'hBAD0_0000, 0, 0, 0, 0, 1);
    n_vec++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0) begin n_err++; $display("FAIL jump_flush got=%b/%h want=0/0", IF_ID_Valid, IF_ID_Instr); end
    n_vec++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_err++; $display("FAIL jump_addr got=%h/%b want=40/1", imem_addr, imem_req); end
    $display("jump: addr=%h", imem_addr);
  endtask

  task automatic test_stall();
    logic [31:0] jw2;
    jw2 = {OPC_J, 26'h7};
    cycle(1, jw2, 1, 0, 0, 0, 0);
    n_vec++; if (imem_req !== 1'b0 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL stall_hold1 got=%b/%b want=0/0", imem_req, IF_ID_Valid); end
    cycle(0, $urandom, 1, 0, 0, 0, 0);
    n_vec++; if (imem_req !== 1'b0 || IF_ID_Instr !== 32'h0) begin n_err++; $display("FAIL stall_hold2 got=%b/%h want=0/0", imem_req, IF_ID_Instr); end
    cycle(0, $urandom, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_Instr !== jw2 || IF_ID_PC4 !== 32'h44 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL stall_release got=%h/%h want=%h/44", IF_ID_Instr, IF_ID_PC4, jw2); end
    n_vec++; if (imem_addr !== 32'h44 || imem_req !== 1'b1) begin n_err++; $display("FAIL stall_next got=%h/%b want=44/1", imem_addr, imem_req); end
    $display("stall release: instr=%h next=%h", IF_ID_Instr, imem_addr);
  endtask

  task automatic test_branch();
    logic [31:0] beq, jx;
    beq = {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE};
    jx  = {OPC_J, 26'h20};
    cycle(1, 32'hBAD0_0001, 0, 0, 0, 0, 1);
    n_vec++; if (imem_addr !== 32'h1C) begin n_err++; $display("FAIL br_setup got=%h want=1c", imem_addr); end
    cycle(1, beq, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_PC4 !== 32'h20 || imem_addr !== 32'h20) begin n_err++; $display("FAIL br_load got=%h/%h want=20/20", IF_ID_PC4, imem_addr); end
    cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFE, 0);
    n_vec++; if (IF_ID_Valid !== 1'b1 || imem_addr !== 32'h20) begin n_err++; $display("FAIL br_not_taken got=%b/%h want=1/20", IF_ID_Valid, imem_addr); end
    cycle(1, 32'hBAD0_0002, 0, 1, 1, 32'hFFFF_FFFE, 0);
    n_vec++; if (imem_addr !== 32'h18 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL br_taken got=%h/%b want=18/0", imem_addr, IF_ID_Valid); end
    cycle(1, beq, 0, 0, 0, 0, 0);
    cycle(1, jx, 0, 1, 0, 32'hFFFF_FFFE, 0);
    n_vec++; if (IF_ID_Instr !== jx || IF_ID_PC4 !== 32'h20 || imem_addr !== 32'h20) begin n_err++; $display("FAIL br_seq got=%h/%h/%h want=%h/20/20", IF_ID_Instr, IF_ID_PC4, imem_addr, jx); end
    $display("branch: taken->18, not-taken sequential pc4=%h", IF_ID_PC4);
  endtask

  task automatic test_discard();
    cycle(0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (IF_ID_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_err++; $display("FAIL disc_hold got=%b/%b/%h want=0/1/20", IF_ID_Valid, imem_req, imem_addr); end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL disc_addr got=%h want=20", imem_addr); end
    cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0 || imem_addr !== 32'h80) begin n_err++; $display("FAIL disc_drop got=%b/%h/%h want=0/0/80", IF_ID_Valid, IF_ID_Instr, imem_addr); end
    cycle(1, 32'h0123_4567, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_Instr !== 32'h0123_4567 || IF_ID_PC4 !== 32'h84) begin n_err++; $display("FAIL disc_refetch got=%h/%h want=01234567/84", IF_ID_Instr, IF_ID_PC4); end
    $display("discard: refetched instr=%h", IF_ID_Instr);
  endtask

  task automatic test_wrap();
    cycle(1, 32'hBAD0_0003, 0, 1, 1, 32'hFFFF_FFDE, 0);
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target got=%h want=fffffffc", imem_addr); end
    cycle(1, 32'h0AAA_5555, 0, 0, 0, 0, 0);
    n_vec++; if (IF_ID_PC4 !== 32'h0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h/%h want=0/0", IF_ID_PC4, imem_addr); end
    $display("wrap: pc4=%h next=%h", IF_ID_PC4, imem_addr);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      cycle(1, mem_word(32'(k * 4)), 0, 0, 0, 0, 0);
      n_vec++; if (IF_ID_PC4 !== 32'((k + 1) * 4) || IF_ID_Instr !== mem_word(32'(k * 4))) begin n_err++; $display("FAIL b2b[%0d] got=%h/%h want=%h/%h", k, IF_ID_PC4, IF_ID_Instr, 32'((k + 1) * 4), mem_word(32'(k * 4))); end
    end
    $display("back-to-back: 4 instructions in 4 cycles");
  endtask

  task automatic test_random();
    int lat;
    int errs_before;
    logic a, st, br, z, j;
    logic [31:0] off;
    lat = 0;
    errs_before = n_err;
    for (int i = 0; i < 3000; i++) begin
      n_vec++;
      if (imem_req !== exp_req() || (exp_req() && imem_addr !== exp_addr()) ||
          IF_ID_Valid !== m_valid || IF_ID_Instr !== m_instr || IF_ID_PC4 !== m_pc4 ||
          OpCode !== m_instr[31:26]) begin
        n_err++;
        $display("FAIL rand[%0d] req=%b/%b addr=%h/%h v=%b/%b instr=%h/%h pc4=%h/%h", i,
                 imem_req, exp_req(), imem_addr, exp_addr(), IF_ID_Valid, m_valid,
                 IF_ID_Instr, m_instr, IF_ID_PC4, m_pc4);
      end
      a = 0;
      if (exp_req()) begin
        if (lat == 0) begin a = 1; lat = $urandom_range(0, 3); end
        else lat--;
      end
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      z   = $urandom_range(0, 1) == 1;
      j   = ($urandom_range(0, 11) == 0);
      off = 32'($urandom_range(0, 64)) - 32'd32;
      cycle(a, a ? mem_word(exp_addr()) : $urandom, st, br, z, off, j);
    end
    $display("random: 3000 cycles, %0d new miscompares", n_err - errs_before);
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL areset_pre got=%b want=1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL areset_drop got=%b/%b want=0/0", imem_req, IF_ID_Valid); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset mid-request: req=%b", imem_req);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_jump();
    test_stall();
    test_branch();
    test_discard();
    test_wrap();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
